// File: rtl/bnn_core_cmd_exec.sv
// BNN core command executor: decodes the 17-bit controller word and runs the
// XNOR-popcount / bias-compare / pooling / packing datapath on 4 columns.
module bnn_core_cmd_exec #(
  parameter int DW    = 16,
  parameter int NCOL  = 4,
  parameter int ACC_W = 8,
  parameter int SUM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16:0]      ctrl,
  input  logic [DW-1:0]    sram_rdata,
  output logic [DW-1:0]    sram_wdata,
  output logic [DW-1:0]    result,
  output logic [4:0]       result_cnt,
  output logic [SUM_W-1:0] sum_o,
  output logic             cmd_err
);

  localparam logic [16:0] CMD_MASK = 17'h0CFA1;
  localparam int          POP_W    = $clog2(DW + 1);

  typedef enum logic [1:0] {LD_NONE, LD_WGT, LD_IMG, LD_BIAS} ld_t;

  logic [DW-1:0]    w_q   [NCOL];
  logic [DW-1:0]    w_d   [NCOL];
  logic [DW-1:0]    i_q   [NCOL];
  logic [DW-1:0]    i_d   [NCOL];
  logic [ACC_W-1:0] acc_q [NCOL];
  logic [ACC_W-1:0] acc_d [NCOL];
  logic [DW-1:0]    bias_q, bias_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             pool_acc_q, pool_acc_d;
  logic [DW-1:0]    result_q, result_d;
  logic [4:0]       result_cnt_q, result_cnt_d;
  ld_t              ld_type_q, ld_type_d;
  logic [1:0]       ld_col_q, ld_col_d;
  logic             ld_half_q, ld_half_d;
  logic             cmd_err_q, cmd_err_d;

  logic [4:0]       n_cmd;
  logic             valid;
  logic [1:0]       col;
  logic [POP_W-1:0] pop;
  logic [DW-1:0]    xnor_w;
  logic [ACC_W:0]   acc_sum;
  logic [SUM_W:0]   sum_sum;
  logic             b_cmp;
  logic             pool_or;
  logic             push_en;
  logic             push_bit;

  // ctrl[4:3] are reserved fields of BPUE/BPUC
  logic unused_reserved;
  assign unused_reserved = ^ctrl[4:3];

  always_comb begin
    w_d          = w_q;
    i_d          = i_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    sum_d        = sum_q;
    pool_acc_d   = pool_acc_q;
    result_d     = result_q;
    result_cnt_d = result_cnt_q;
    ld_type_d    = LD_NONE;
    ld_col_d     = ctrl[2:1];
    ld_half_d    = ctrl[16];
    sram_wdata   = '0;
    push_en      = 1'b0;
    push_bit     = 1'b0;
    col          = ctrl[2:1];

    n_cmd = '0;
    for (int unsigned k = 0; k < 17; k++) begin
      n_cmd = n_cmd + {4'b0, ctrl[k] & CMD_MASK[k]};
    end
    valid     = (n_cmd <= 5'd1);
    cmd_err_d = !valid;

    xnor_w = ~(w_q[col] ^ i_q[col]);
    pop    = '0;
    for (int unsigned k = 0; k < DW; k++) begin
      pop = pop + {{(POP_W-1){1'b0}}, xnor_w[k]};
    end
    acc_sum = {1'b0, acc_q[col]} + (ACC_W+1)'(pop);
    sum_sum = {1'b0, sum_q} + (SUM_W+1)'(acc_q[col]);
    b_cmp   = (DW'(sum_q) >= bias_q);
    pool_or = pool_acc_q | b_cmp;

    if (valid) begin
      if (ctrl[0]) begin
        for (int unsigned k = 0; k < NCOL; k++) acc_d[k] = '0;
        sum_d      = '0;
        pool_acc_d = 1'b0;
      end
      if (ctrl[5]) acc_d[col] = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      if (ctrl[9]) sum_d = sum_sum[SUM_W] ? '1 : sum_sum[SUM_W-1:0];
      if (ctrl[10]) begin
        if (!ctrl[12]) begin
          push_en  = 1'b1;
          push_bit = b_cmp;
        end else if ({ctrl[6], ctrl[13]} == 2'd3) begin
          push_en    = 1'b1;
          push_bit   = pool_or;
          pool_acc_d = 1'b0;
        end else begin
          pool_acc_d = pool_or;
        end
      end
      if (ctrl[14]) begin
        sram_wdata   = ctrl[6] ? DW'(sum_q) : result_q;
        result_cnt_d = '0;
      end
      if (ctrl[15]) begin
        for (int unsigned k = 0; k + 1 < NCOL; k++) i_d[k] = i_q[k+1];
        i_d[NCOL-1] = '0;
      end
      if (ctrl[7])  ld_type_d = LD_WGT;
      if (ctrl[8])  ld_type_d = LD_IMG;
      if (ctrl[11]) ld_type_d = LD_BIAS;
    end

    if (push_en) begin
      result_d = {result_q[DW-2:0], push_bit};
      if (result_cnt_q < 5'd16) result_cnt_d = result_cnt_q + 5'd1;
    end

    // Pending load lands after SHIFT so an IMG write into a shifted column wins.
    unique case (ld_type_q)
      LD_WGT:  w_d[ld_col_q] = sram_rdata;
      LD_BIAS: bias_d = sram_rdata;
      LD_IMG: begin
        if (ld_half_q) i_d[ld_col_q][DW-1:DW/2] = sram_rdata[DW/2-1:0];
        else           i_d[ld_col_q][DW/2-1:0]  = sram_rdata[DW/2-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCOL; k++) begin
        w_q[k]   <= '0;
        i_q[k]   <= '0;
        acc_q[k] <= '0;
      end
      bias_q       <= '0;
      sum_q        <= '0;
      pool_acc_q   <= 1'b0;
      result_q     <= '0;
      result_cnt_q <= '0;
      ld_type_q    <= LD_NONE;
      ld_col_q     <= '0;
      ld_half_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      w_q          <= w_d;
      i_q          <= i_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      sum_q        <= sum_d;
      pool_acc_q   <= pool_acc_d;
      result_q     <= result_d;
      result_cnt_q <= result_cnt_d;
      ld_type_q    <= ld_type_d;
      ld_col_q     <= ld_col_d;
      ld_half_q    <= ld_half_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign result     = result_q;
  assign result_cnt = result_cnt_q;
  assign sum_o      = sum_q;
  assign cmd_err    = cmd_err_q;

endmodule
